cp0_regfile: RTL and testbench
==============================

CP0_REGFILE -- requirements
Module: cp0_regfile

Interface
REQ-001 SHALL have parameter TLB_ENTRIES, default 32, the TLB entry count; Random and Wired are 5 bits wide.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports ra  input  5  and rsel  input  3, the read register number and select.
REQ-005 SHALL have port rdata  output  32  combinational read data for ra/rsel.
REQ-006 SHALL have ports we  input  1, wa  input  5, wsel  input  3, wdata  input  32, the MTC0 write.
REQ-007 SHALL have ports exc_valid  input  1, exc_code  input  5, exc_pc  input  32, exc_bd  input  1, exc_bva_valid  input  1, exc_bva  input  32, the commit-stage exception report.
REQ-008 SHALL have port eret  input  1  ERET commit strobe.
REQ-009 SHALL have port ext_int  input  6  hardware interrupt lines, level-sensitive.
REQ-010 SHALL have ports int_req  output  1, epc  output  32, status_exl  output  1.

Function
REQ-011 SHALL return from rdata the current register value, with no write bypass: Index 0, Random 1, EntryLo0 2, EntryLo1 3, Context 4, PageMask 5, Wired 6, BadVAddr 8, Count 9, EntryHi 10, Compare 11, Status 12, Cause 13, EPC 14, PRId 15, Config 16 sel0, Config1 16 sel1; all other addresses and selects read 0.
REQ-012 SHALL apply these write masks and treat all other bits as read-only:
- Status: IM[15:8], EXL[1], IE[0].
- Cause: IP[9:8].
- EntryHi: [31:13], [7:0].
- EntryLo0/1: [29:0].
- Index: [4:0].
- Wired: [4:0].
- Context: [31:23].
- PageMask: [28:13].
- Config: K0[2:0].
- Count, Compare, EPC: all 32 bits.
REQ-013 SHALL hold BadVAddr, PRId and Config1 read-only: PRId 0x0001_8000, Config1 0x3E00_0000.
REQ-014 SHALL increment Count every second clk using an internal toggle bit; an MTC0 to Count loads wdata and clears the toggle, and the first increment follows two cycles later.
REQ-015 SHALL set Cause.TI on the cycle after Count equals Compare with the toggle about to increment; TI SHALL stay set until an MTC0 to Compare, which clears TI.
REQ-016 SHALL register Cause.IP[15:10] as {ext_int[5] | TI, ext_int[4:0]} every cycle.
REQ-017 SHALL drive int_req as Status.IE & ~Status.EXL & |(Cause.IP & Status.IM), combinational from registers.
REQ-018 SHALL decrement Random every cycle; when Random equals Wired, or equals 0, the next value SHALL be TLB_ENTRIES-1; an MTC0 to Wired SHALL force Random to TLB_ENTRIES-1.
REQ-019 SHALL, on exc_valid with Status.EXL=0, load EPC with exc_bd ? exc_pc-4 : exc_pc and load Cause.BD with exc_bd.
REQ-020 SHALL, on exc_valid with Status.EXL=1, leave EPC and Cause.BD unchanged.
REQ-021 SHALL, on any exc_valid, load Cause.ExcCode with exc_code and set Status.EXL.
REQ-022 SHALL, on exc_valid with exc_bva_valid, load BadVAddr with exc_bva, load Context.BadVPN2 with exc_bva[31:13], and load EntryHi.VPN2 with exc_bva[31:13] when exc_code is 1, 2 or 3.
REQ-023 SHALL clear Status.EXL on eret without exc_valid.
REQ-024 SHALL resolve simultaneous events as exc_valid > eret > MTC0: an MTC0 in the same cycle as exc_valid or eret is dropped entirely, and the hardware updates of Count, Random and IP still occur.
REQ-025 SHALL let an MTC0 to Count or Compare in the same cycle as a compare match take precedence, so the write value is stored and TI is not set.
REQ-026 SHALL drive epc and status_exl directly from the EPC register and Status.EXL.

Reset
REQ-027 SHALL, while resetn=0 (asynchronous), force these values:
- Status 0x0040_0000 (BEV=1).
- Cause 0; Count 0; Compare 0; EPC 0; BadVAddr 0; Index 0; Wired 0.
- EntryHi, EntryLo0/1, Context, PageMask 0.
- Random TLB_ENTRIES-1 (31).
- Config 0x8000_0083; Count toggle 0.
REQ-028 SHALL, while resetn=0, output int_req=0, status_exl=0, epc=0.
REQ-029 SHALL resume normal operation on the first rising clk edge after resetn deasserts; reset mid-exception discards all pending updates.

Verification
REQ-030 Reset: resetn low then high -> rdata(12)=0x0040_0000, rdata(16,0)=0x8000_0083, rdata(16,1)=0x3E00_0000, rdata(1)=31, int_req=0.
REQ-031 Timer: MTC0 Compare=5, Count=0, Status=0x0000_8001 -> TI=1, Cause.IP[15]=1 and int_req=1 about 10-11 cycles later; MTC0 Compare=100 -> TI=0 and int_req=0 next cycle.
REQ-032 Exception in delay slot: exc_valid, exc_code=4, exc_pc=0xBFC0_0104, exc_bd=1, exc_bva=0x1234_5671 -> EPC=0xBFC0_0100, Cause=0x8000_0010, EXL=1, BadVAddr=0x1234_5671.
REQ-033 Nested exception then ERET: second exc_valid with exc_pc=0x8000_0000 while EXL=1 -> EPC unchanged, ExcCode updated; eret -> EXL=0; eret with exc_valid in the same cycle -> EXL stays 1.
REQ-034 Random/Wired: MTC0 Wired=30 -> Random reads 31, 30, 31, 30; MTC0 to Status with exc_valid in the same cycle -> Status.IM unchanged.
REQ-035 Masks: MTC0 0xFFFF_FFFF to Cause -> reads 0x0000_0300; the same value to EntryHi -> reads 0xFFFF_E0FF.

Source files
------------

// File: rtl/cp0_regfile.sv
// MIPS32-style CP0 register file: TLB support registers, Count/Compare timer,
// Status/Cause interrupt state and precise exception capture (EPC, BadVAddr).
module cp0_regfile #(
  parameter int unsigned TLB_ENTRIES = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [4:0]  ra,
  input  logic [2:0]  rsel,
  output logic [31:0] rdata,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [2:0]  wsel,
  input  logic [31:0] wdata,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic        exc_bva_valid,
  input  logic [31:0] exc_bva,
  input  logic        eret,
  input  logic [5:0]  ext_int,
  output logic        int_req,
  output logic [31:0] epc,
  output logic        status_exl
);

  localparam logic [4:0] RandTop = 5'(TLB_ENTRIES - 1);

  localparam logic [4:0] RegIndex    = 5'd0;
  localparam logic [4:0] RegRandom   = 5'd1;
  localparam logic [4:0] RegEntryLo0 = 5'd2;
  localparam logic [4:0] RegEntryLo1 = 5'd3;
  localparam logic [4:0] RegContext  = 5'd4;
  localparam logic [4:0] RegPageMask = 5'd5;
  localparam logic [4:0] RegWired    = 5'd6;
  localparam logic [4:0] RegBadVAddr = 5'd8;
  localparam logic [4:0] RegCount    = 5'd9;
  localparam logic [4:0] RegEntryHi  = 5'd10;
  localparam logic [4:0] RegCompare  = 5'd11;
  localparam logic [4:0] RegStatus   = 5'd12;
  localparam logic [4:0] RegCause    = 5'd13;
  localparam logic [4:0] RegEpc      = 5'd14;
  localparam logic [4:0] RegPrid     = 5'd15;
  localparam logic [4:0] RegConfig   = 5'd16;

  localparam logic [31:0] PridVal    = 32'h0001_8000;
  localparam logic [31:0] Config1Val = 32'h3E00_0000;
  // Config bits above K0 are fixed: 0x8000_0080 >> 3
  localparam logic [28:0] ConfigHi   = 29'h1000_0010;

  logic [4:0]  index_q, index_d;
  logic [4:0]  random_q, random_d;
  logic [29:0] entrylo0_q, entrylo0_d;
  logic [29:0] entrylo1_q, entrylo1_d;
  logic [8:0]  ctx_ptebase_q, ctx_ptebase_d;
  logic [18:0] ctx_badvpn2_q, ctx_badvpn2_d;
  logic [15:0] pagemask_q, pagemask_d;
  logic [4:0]  wired_q, wired_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] count_q, count_d;
  logic        tick_q, tick_d;
  logic [18:0] entryhi_vpn2_q, entryhi_vpn2_d;
  logic [7:0]  entryhi_asid_q, entryhi_asid_d;
  logic [31:0] compare_q, compare_d;
  logic [7:0]  status_im_q, status_im_d;
  logic        status_exl_q, status_exl_d;
  logic        status_ie_q, status_ie_d;
  logic        cause_bd_q, cause_bd_d;
  logic        cause_ti_q, cause_ti_d;
  logic [5:0]  cause_ip_hw_q, cause_ip_hw_d;
  logic [1:0]  cause_ip_sw_q, cause_ip_sw_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [31:0] epc_q, epc_d;
  logic [2:0]  config_k0_q, config_k0_d;

  logic wr_en, wr_count, wr_compare, wr_wired, timer_hit;

  // Exceptions and ERET both squash a same-cycle MTC0.
  assign wr_en      = we & ~exc_valid & ~eret & (wsel == 3'd0);
  assign wr_count   = wr_en & (wa == RegCount);
  assign wr_compare = wr_en & (wa == RegCompare);
  assign wr_wired   = wr_en & (wa == RegWired);
  assign timer_hit  = tick_q & (count_q == compare_q) & ~wr_count & ~wr_compare;

  always_comb begin
    index_d        = index_q;
    random_d       = random_q;
    entrylo0_d     = entrylo0_q;
    entrylo1_d     = entrylo1_q;
    ctx_ptebase_d  = ctx_ptebase_q;
    ctx_badvpn2_d  = ctx_badvpn2_q;
    pagemask_d     = pagemask_q;
    wired_d        = wired_q;
    badvaddr_d     = badvaddr_q;
    entryhi_vpn2_d = entryhi_vpn2_q;
    entryhi_asid_d = entryhi_asid_q;
    compare_d      = compare_q;
    status_im_d    = status_im_q;
    status_exl_d   = status_exl_q;
    status_ie_d    = status_ie_q;
    cause_bd_d     = cause_bd_q;
    cause_ti_d     = cause_ti_q;
    cause_ip_sw_d  = cause_ip_sw_q;
    cause_exc_d    = cause_exc_q;
    epc_d          = epc_q;
    config_k0_d    = config_k0_q;

    // Free-running hardware updates, independent of the priority chain below.
    tick_d  = ~tick_q;
    count_d = count_q + {31'd0, tick_q};

    if (wr_compare) begin
      cause_ti_d = 1'b0;
    end else if (timer_hit) begin
      cause_ti_d = 1'b1;
    end
    cause_ip_hw_d = {ext_int[5] | cause_ti_d, ext_int[4:0]};

    if (wr_wired || (random_q == wired_q) || (random_q == 5'd0)) begin
      random_d = RandTop;
    end else begin
      random_d = random_q - 5'd1;
    end

    if (exc_valid) begin
      // A nested exception keeps the original return point.
      if (!status_exl_q) begin
        epc_d      = exc_bd ? (exc_pc - 32'd4) : exc_pc;
        cause_bd_d = exc_bd;
      end
      cause_exc_d  = exc_code;
      status_exl_d = 1'b1;
      if (exc_bva_valid) begin
        badvaddr_d    = exc_bva;
        ctx_badvpn2_d = exc_bva[31:13];
        if (exc_code inside {5'd1, 5'd2, 5'd3}) begin
          entryhi_vpn2_d = exc_bva[31:13];
        end
      end
    end else if (eret) begin
      status_exl_d = 1'b0;
    end else if (wr_en) begin
      unique case (wa)
        RegIndex:    index_d = wdata[4:0];
        RegEntryLo0: entrylo0_d = wdata[29:0];
        RegEntryLo1: entrylo1_d = wdata[29:0];
        RegContext:  ctx_ptebase_d = wdata[31:23];
        RegPageMask: pagemask_d = wdata[28:13];
        RegWired:    wired_d = wdata[4:0];
        RegCount: begin
          count_d = wdata;
          tick_d  = 1'b0;
        end
        RegEntryHi: begin
          entryhi_vpn2_d = wdata[31:13];
          entryhi_asid_d = wdata[7:0];
        end
        RegCompare:  compare_d = wdata;
        RegStatus: begin
          status_im_d  = wdata[15:8];
          status_exl_d = wdata[1];
          status_ie_d  = wdata[0];
        end
        RegCause:    cause_ip_sw_d = wdata[9:8];
        RegEpc:      epc_d = wdata;
        RegConfig:   config_k0_d = wdata[2:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      index_q        <= '0;
      random_q       <= RandTop;
      entrylo0_q     <= '0;
      entrylo1_q     <= '0;
      ctx_ptebase_q  <= '0;
      ctx_badvpn2_q  <= '0;
      pagemask_q     <= '0;
      wired_q        <= '0;
      badvaddr_q     <= '0;
      count_q        <= '0;
      tick_q         <= 1'b0;
      entryhi_vpn2_q <= '0;
      entryhi_asid_q <= '0;
      compare_q      <= '0;
      status_im_q    <= '0;
      status_exl_q   <= 1'b0;
      status_ie_q    <= 1'b0;
      cause_bd_q     <= 1'b0;
      cause_ti_q     <= 1'b0;
      cause_ip_hw_q  <= '0;
      cause_ip_sw_q  <= '0;
      cause_exc_q    <= '0;
      epc_q          <= '0;
      config_k0_q    <= 3'd3;
    end else begin
      index_q        <= index_d;
      random_q       <= random_d;
      entrylo0_q     <= entrylo0_d;
      entrylo1_q     <= entrylo1_d;
      ctx_ptebase_q  <= ctx_ptebase_d;
      ctx_badvpn2_q  <= ctx_badvpn2_d;
      pagemask_q     <= pagemask_d;
      wired_q        <= wired_d;
      badvaddr_q     <= badvaddr_d;
      count_q        <= count_d;
      tick_q         <= tick_d;
      entryhi_vpn2_q <= entryhi_vpn2_d;
      entryhi_asid_q <= entryhi_asid_d;
      compare_q      <= compare_d;
      status_im_q    <= status_im_d;
      status_exl_q   <= status_exl_d;
      status_ie_q    <= status_ie_d;
      cause_bd_q     <= cause_bd_d;
      cause_ti_q     <= cause_ti_d;
      cause_ip_hw_q  <= cause_ip_hw_d;
      cause_ip_sw_q  <= cause_ip_sw_d;
      cause_exc_q    <= cause_exc_d;
      epc_q          <= epc_d;
      config_k0_q    <= config_k0_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (rsel == 3'd0) begin
      case (ra)
        RegIndex:    rdata = {27'd0, index_q};
        RegRandom:   rdata = {27'd0, random_q};
        RegEntryLo0: rdata = {2'd0, entrylo0_q};
        RegEntryLo1: rdata = {2'd0, entrylo1_q};
        RegContext:  rdata = {ctx_ptebase_q, ctx_badvpn2_q, 4'd0};
        RegPageMask: rdata = {3'd0, pagemask_q, 13'd0};
        RegWired:    rdata = {27'd0, wired_q};
        RegBadVAddr: rdata = badvaddr_q;
        RegCount:    rdata = count_q;
        RegEntryHi:  rdata = {entryhi_vpn2_q, 5'd0, entryhi_asid_q};
        RegCompare:  rdata = compare_q;
        RegStatus:   rdata = {9'd0, 1'b1, 6'd0, status_im_q, 6'd0, status_exl_q, status_ie_q};
        RegCause:    rdata = {cause_bd_q, cause_ti_q, 14'd0, cause_ip_hw_q, cause_ip_sw_q,
                              1'b0, cause_exc_q, 2'd0};
        RegEpc:      rdata = epc_q;
        RegPrid:     rdata = PridVal;
        RegConfig:   rdata = {ConfigHi, config_k0_q};
        default:     rdata = '0;
      endcase
    end else if ((rsel == 3'd1) && (ra == RegConfig)) begin
      rdata = Config1Val;
    end
  end

  assign int_req    = status_ie_q & ~status_exl_q &
                      (|({cause_ip_hw_q, cause_ip_sw_q} & status_im_q));
  assign epc        = epc_q;
  assign status_exl = status_exl_q;

endmodule

// File: tb/tb_cp0_regfile.sv
// Scoreboard bench for cp0_regfile: stimulus pushes model predictions, a negedge
// monitor pops them and compares rdata, int_req, epc and status_exl.
module tb_cp0_regfile;

  localparam logic [4:0] Top = 5'd31;

  logic        clk;
  logic        resetn;
  logic [4:0]  ra, wa, exc_code;
  logic [2:0]  rsel, wsel;
  logic [31:0] rdata, wdata, exc_pc, exc_bva, epc;
  logic        we, exc_valid, exc_bd, exc_bva_valid, eret, int_req, status_exl;
  logic [5:0]  ext_int;
  logic        chk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        irq;
    logic [31:0] epc;
    logic        exl;
  } item_t;
  item_t exp_q[$];

  cp0_regfile #(.TLB_ENTRIES(32)) dut (
    .clk(clk), .resetn(resetn), .ra(ra), .rsel(rsel), .rdata(rdata),
    .we(we), .wa(wa), .wsel(wsel), .wdata(wdata),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .exc_bva_valid(exc_bva_valid), .exc_bva(exc_bva), .eret(eret), .ext_int(ext_int),
    .int_req(int_req), .epc(epc), .status_exl(status_exl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural register contents; Count is derived from the
  // value last loaded and the number of clocks since (one step per two clocks).
  logic [4:0]  m_index, m_random, m_wired, m_exc;
  logic [31:0] m_lo0, m_lo1, m_ctx, m_pmask, m_ehi, m_bva, m_cnt_base, m_cmp;
  logic [31:0] m_status, m_epc, m_config;
  int unsigned m_cnt_n;
  logic        m_bd, m_ti;
  logic [7:0]  m_ip;

  function automatic logic [31:0] m_count();
    return m_cnt_base + (m_cnt_n >> 1);
  endfunction

  function automatic logic [31:0] m_cause();
    return {m_bd, m_ti, 14'd0, m_ip, 1'b0, m_exc, 2'd0};
  endfunction

  function automatic logic m_irq();
    return m_status[0] & ~m_status[1] & (|(m_ip & m_status[15:8]));
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic [2:0] s);
    if (s == 3'd1 && a == 5'd16) return 32'h3E00_0000;
    if (s != 3'd0) return 32'h0;
    case (a)
      5'd0:  return {27'd0, m_index};
      5'd1:  return {27'd0, m_random};
      5'd2:  return m_lo0;
      5'd3:  return m_lo1;
      5'd4:  return m_ctx;
      5'd5:  return m_pmask;
      5'd6:  return {27'd0, m_wired};
      5'd8:  return m_bva;
      5'd9:  return m_count();
      5'd10: return m_ehi;
      5'd11: return m_cmp;
      5'd12: return m_status;
      5'd13: return m_cause();
      5'd14: return m_epc;
      5'd15: return 32'h0001_8000;
      5'd16: return m_config;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    m_index = '0; m_random = Top; m_wired = '0; m_exc = '0;
    m_lo0 = '0; m_lo1 = '0; m_ctx = '0; m_pmask = '0; m_ehi = '0; m_bva = '0;
    m_cnt_base = '0; m_cnt_n = 0; m_cmp = '0; m_status = 32'h0040_0000; m_epc = '0;
    m_config = 32'h8000_0083; m_bd = 1'b0; m_ti = 1'b0; m_ip = '0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nv,
                                        input logic [31:0] mask);
    return (old & ~mask) | (nv & mask);
  endfunction

  task automatic m_step();
    logic wr;
    logic match;
    wr    = we && !exc_valid && !eret && (wsel == 3'd0);
    match = (m_count() == m_cmp) && (m_cnt_n % 2 == 1);
    if (wr && wa == 5'd11) m_ti = 1'b0;
    else if (match && !(wr && wa == 5'd9)) m_ti = 1'b1;
    m_ip[7:2] = {ext_int[5] | m_ti, ext_int[4:0]};
    if ((wr && wa == 5'd6) || m_random == m_wired || m_random == 5'd0) m_random = Top;
    else m_random = m_random - 5'd1;
    m_cnt_n++;
    if (exc_valid) begin
      if (!m_status[1]) begin
        m_epc = exc_bd ? exc_pc - 32'd4 : exc_pc;
        m_bd  = exc_bd;
      end
      m_exc = exc_code;
      m_status[1] = 1'b1;
      if (exc_bva_valid) begin
        m_bva = exc_bva;
        m_ctx = {m_ctx[31:23], exc_bva[31:13], m_ctx[3:0]};
        if (exc_code >= 5'd1 && exc_code <= 5'd3) m_ehi = {exc_bva[31:13], m_ehi[12:0]};
      end
    end else if (eret) begin
      m_status[1] = 1'b0;
    end else if (wr) begin
      case (wa)
        5'd0:  m_index = wdata[4:0];
        5'd2:  m_lo0 = wdata & 32'h3FFF_FFFF;
        5'd3:  m_lo1 = wdata & 32'h3FFF_FFFF;
        5'd4:  m_ctx = merge(m_ctx, wdata, 32'hFF80_0000);
        5'd5:  m_pmask = wdata & 32'h1FFF_E000;
        5'd6:  m_wired = wdata[4:0];
        5'd9:  begin m_cnt_base = wdata; m_cnt_n = 0; end
        5'd10: m_ehi = wdata & 32'hFFFF_E0FF;
        5'd11: m_cmp = wdata;
        5'd12: m_status = merge(m_status, wdata, 32'h0000_FF03);
        5'd13: m_ip[1:0] = wdata[9:8];
        5'd14: m_epc = wdata;
        5'd16: m_config = merge(m_config, wdata, 32'h0000_0007);
        default: ;
      endcase
    end
  endtask

  // Push the expectation for the current state, advance the model, take one clock.
  task automatic issue(input string name, input bit use_c, input logic [31:0] cval);
    item_t it;
    if (!resetn) m_reset();
    it.name  = name;
    it.rdata = use_c ? cval : m_read(ra, rsel);
    it.irq   = m_irq();
    it.epc   = m_epc;
    it.exl   = m_status[1];
    exp_q.push_back(it);
    chk = 1'b1;
    if (resetn) m_step();
    @(posedge clk);
    #2;
    we = 1'b0; exc_valid = 1'b0; eret = 1'b0; exc_bva_valid = 1'b0;
  endtask

  task automatic rd(input string name, input logic [4:0] a, input logic [2:0] s,
                    input logic [31:0] c);
    ra = a; rsel = s;
    issue(name, 1'b1, c);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; wa = a; wsel = 3'd0; wdata = d;
    issue("mtc0", 1'b0, 32'h0);
  endtask

  task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                     input logic bvav, input logic [31:0] bva, input logic with_eret);
    exc_valid = 1'b1; exc_code = code; exc_pc = pc; exc_bd = bd;
    exc_bva_valid = bvav; exc_bva = bva; eret = with_eret;
    issue("exc", 1'b0, 32'h0);
  endtask

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  initial begin : monitor
    item_t it;
    forever begin
      @(negedge clk);
      if (chk) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard_underflow got=empty required=item");
        end else begin
          it = exp_q.pop_front();
          cmp({"rdata_", it.name}, rdata, it.rdata);
          cmp({"int_req_", it.name}, {31'd0, int_req}, {31'd0, it.irq});
          cmp({"epc_", it.name}, epc, it.epc);
          cmp({"exl_", it.name}, {31'd0, status_exl}, {31'd0, it.exl});
        end
      end
    end
  end

  logic [4:0] wr_addrs [16] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8,
                                5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16};

  initial begin : stimulus
    chk = 1'b0; resetn = 1'b0;
    ra = '0; rsel = '0; we = 1'b0; wa = '0; wsel = '0; wdata = '0;
    exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_bd = 1'b0;
    exc_bva_valid = 1'b0; exc_bva = '0; eret = 1'b0; ext_int = '0;
    m_reset();
    @(posedge clk);
    #2;

    rd("rst_status",  5'd12, 3'd0, 32'h0040_0000);
    rd("rst_config",  5'd16, 3'd0, 32'h8000_0083);
    rd("rst_config1", 5'd16, 3'd1, 32'h3E00_0000);
    rd("rst_random",  5'd1,  3'd0, 32'h0000_001F);
    rd("rst_prid",    5'd15, 3'd0, 32'h0001_8000);
    resetn = 1'b1;

    // Timer interrupt
    ra = 5'd13; rsel = 3'd0;
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    mtc0(5'd12, 32'h0000_8001);
    for (int i = 0; i < 12; i++) issue("timer_poll", 1'b0, 32'h0);
    rd("timer_ti", 5'd13, 3'd0, 32'h4000_8000);
    rd("timer_status", 5'd12, 3'd0, 32'h0040_8001);
    mtc0(5'd11, 32'd100);
    rd("timer_clear", 5'd13, 3'd0, 32'h0000_0000);

    // Delay-slot exception
    exc(5'd4, 32'hBFC0_0104, 1'b1, 1'b1, 32'h1234_5671, 1'b0);
    rd("exc_epc",    5'd14, 3'd0, 32'hBFC0_0100);
    rd("exc_cause",  5'd13, 3'd0, 32'h8000_0010);
    rd("exc_status", 5'd12, 3'd0, 32'h0040_8003);
    rd("exc_bva",    5'd8,  3'd0, 32'h1234_5671);

    // Nested exception, ERET, ERET racing an exception
    exc(5'd5, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b0);
    rd("nest_epc",   5'd14, 3'd0, 32'hBFC0_0100);
    rd("nest_cause", 5'd13, 3'd0, 32'h8000_0014);
    eret = 1'b1;
    issue("eret", 1'b0, 32'h0);
    rd("eret_status", 5'd12, 3'd0, 32'h0040_8001);
    exc(5'd0, 32'h8000_1000, 1'b0, 1'b0, 32'h0, 1'b1);
    rd("race_status", 5'd12, 3'd0, 32'h0040_8003);
    rd("race_epc",    5'd14, 3'd0, 32'h8000_1000);
    rd("race_cause",  5'd13, 3'd0, 32'h0000_0000);
    eret = 1'b1;
    issue("eret", 1'b0, 32'h0);

    // Random/Wired and an MTC0 squashed by an exception
    mtc0(5'd6, 32'd30);
    rd("random_0", 5'd1, 3'd0, 32'd31);
    rd("random_1", 5'd1, 3'd0, 32'd30);
    rd("random_2", 5'd1, 3'd0, 32'd31);
    rd("random_3", 5'd1, 3'd0, 32'd30);
    we = 1'b1; wa = 5'd12; wsel = 3'd0; wdata = 32'h0;
    exc(5'd0, 32'h8000_2000, 1'b0, 1'b0, 32'h0, 1'b0);
    rd("squash_status", 5'd12, 3'd0, 32'h0040_8003);
    eret = 1'b1;
    issue("eret", 1'b0, 32'h0);
    mtc0(5'd6, 32'd0);

    // Write masks
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd("mask_cause", 5'd13, 3'd0, 32'h0000_0300);
    mtc0(5'd10, 32'hFFFF_FFFF);
    rd("mask_entryhi", 5'd10, 3'd0, 32'hFFFF_E0FF);
    mtc0(5'd5, 32'hFFFF_FFFF);
    rd("mask_pagemask", 5'd5, 3'd0, 32'h1FFF_E000);

    // Randomized traffic against the model, with one asynchronous reset midway
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        resetn = 1'b0;
        rd("mid_rst_status", 5'd12, 3'd0, 32'h0040_0000);
        rd("mid_rst_random", 5'd1,  3'd0, 32'h0000_001F);
        resetn = 1'b1;
      end
      if ($urandom_range(0, 1) == 0) ra = wr_addrs[$urandom_range(0, 15)];
      else ra = 5'($urandom_range(0, 31));
      rsel = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      if (ra == 5'd16 && $urandom_range(0, 1) == 0) rsel = 3'd1;
      if ($urandom_range(0, 3) == 0) begin
        we    = 1'b1;
        wa    = wr_addrs[$urandom_range(0, 15)];
        wsel  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
        wdata = $urandom();
        if (wa == 5'd11 && $urandom_range(0, 1) == 0)
          wdata = m_count() + 32'($urandom_range(0, 6));
      end
      if ($urandom_range(0, 15) == 0) begin
        exc_valid     = 1'b1;
        exc_code      = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(1, 3))
                                                    : 5'($urandom_range(0, 31));
        exc_pc        = $urandom() & 32'hFFFF_FFFC;
        exc_bd        = 1'($urandom_range(0, 1));
        exc_bva_valid = 1'($urandom_range(0, 1));
        exc_bva       = $urandom();
      end
      if ($urandom_range(0, 15) == 0) eret = 1'b1;
      if ($urandom_range(0, 31) == 0) ext_int = 6'($urandom_range(0, 63));
      issue("rand", 1'b0, 32'h0);
    end

    chk = 1'b0;
    @(negedge clk);
    cmp("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
